counter_ctrl: RTL

//   Control unit that sits directly upstream of the up/down counter datapath.
//   - Accepts step commands over a valid/ready handshake.
//   - Drives the datapath's op / c_ld / c_clr inputs.
//   - Reads back the datapath's z (zero) and m (MSB/negative) flags.
//   - Reports completion with a done pulse and an optional saturation flag.

---
 rtl/counter_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//   Control unit that sits directly upstream of the up/down counter datapath.
//   It accepts step commands over a valid/ready handshake and drives the
//   datapath's op / c_ld / c_clr strobes. It reads back the datapath zero (z)
//   and MSB (m) flags, and reports completion with a one-cycle done pulse.
//
//   Optional feature macro: COUNTER_CTRL_SAT_EN
//     defined   : a decrement run that reaches zero with steps still pending
//                 finishes early with sat=1. The counter never goes below 0.
//     undefined : decrements wrap (0 -> 0xFFFF) and sat is tied to 0.
//
// Parameters
//   N_W        width of cmd_n (steps per command)
//
// Ports
//   clk        in   1    system clock, rising edge
//   reset      in   1    asynchronous reset, active-low
//   cmd_valid  in   1    command present
//   cmd_ready  out  1    controller can accept (only in IDLE)
//   cmd_op     in   2    00=inc, 01=dec, 10=clear, 11=no-op
//   cmd_n      in   N_W  number of inc/dec steps
//   z          in   1    datapath counter == 0
//   m          in   1    datapath counter MSB
//   op         out  1    datapath direction: 0=inc, 1=dec
//   c_ld       out  1    datapath load strobe, one cycle per step
//   c_clr      out  1    datapath clear strobe
//   busy       out  1    command in progress
//   done       out  1    one-cycle completion pulse
//   sat        out  1    with done: decrement run stopped at zero
//   res_z      out  1    z captured during the done cycle, held until next done
//   res_m      out  1    m captured during the done cycle, held until next done
// -----------------------------------------------------------------------------
module counter_ctrl #(
    parameter int unsigned N_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [N_W-1:0] cmd_n,
    input  logic           z,
    input  logic           m,
    output logic           op,
    output logic           c_ld,
    output logic           c_clr,
    output logic           busy,
    output logic           done,
    output logic           sat,
    output logic           res_z,
    output logic           res_m
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CHECK,
        S_STEP,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    // Only the direction bit of the accepted command is kept. CHECK/STEP are
    // reached solely for inc/dec, so bit 0 alone distinguishes them.
    logic           op_r;
    logic [N_W-1:0] rem;
    logic           sat_hit;

`ifdef COUNTER_CTRL_SAT_EN
    logic           sat_r;

    // Evaluated in CHECK: z already reflects the previous STEP's update.
    assign sat_hit = op_r && z && (rem != '0);
`else
    assign sat_hit = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            op_r  <= 1'b0;
            rem   <= '0;
            res_z <= 1'b0;
            res_m <= 1'b0;
`ifdef COUNTER_CTRL_SAT_EN
            sat_r <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_r  <= cmd_op[0];
                        rem   <= cmd_n;
`ifdef COUNTER_CTRL_SAT_EN
                        sat_r <= 1'b0;
`endif
                    end
                end
                S_STEP: begin
                    rem <= rem - N_W'(1);
                end
`ifdef COUNTER_CTRL_SAT_EN
                S_CHECK: begin
                    sat_r <= sat_hit;
                end
`endif
                S_DONE: begin
                    res_z <= z;
                    res_m <= m;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b10:   state_nx = S_CLEAR;
                        2'b11:   state_nx = S_DONE;
                        default: state_nx = S_CHECK;
                    endcase
                end
            end
            S_CLEAR: state_nx = S_DONE;
            S_CHECK: begin
                if ((rem == '0) || sat_hit)
                    state_nx = S_DONE;
                else
                    state_nx = S_STEP;
            end
            S_STEP:  state_nx = S_CHECK;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        c_clr     = (state == S_CLEAR);
        c_ld      = (state == S_STEP);
        done      = (state == S_DONE);
        op        = (state != S_IDLE) && op_r;
    end

`ifdef COUNTER_CTRL_SAT_EN
    assign sat = (state == S_DONE) && sat_r;
`else
    assign sat = 1'b0;
`endif

endmodule
